// File: rtl/sort_vote_overlay.sv
// Majority vote over recent frame sort codes plus bounding-box overlay.
// Video path is a fixed 1-cycle register stage; the vote runs in vblank.
module sort_vote_overlay #(
    parameter int          HIST_DEPTH = 8,
    parameter int          NUM_CLASS  = 12,
    parameter int          MIN_VOTES  = 5,
    parameter int          LINE_W     = 2,
    parameter logic [23:0] BOX_COLOR  = 24'hFF0000
) (
    input  logic        pixelclk,
    input  logic        rstin,
    input  logic [3:0]  i_sort,
    input  logic [11:0] hcount_l,
    input  logic [11:0] hcount_r,
    input  logic [11:0] vcount_l,
    input  logic [11:0] vcount_r,
    input  logic [23:0] i_rgb,
    input  logic        i_hsync,
    input  logic        i_vsync,
    input  logic        i_de,
    output logic [23:0] o_rgb,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic [3:0]  o_sort,
    output logic        o_sort_valid,
    output logic        o_frame_done
);

    localparam int CW = $clog2(HIST_DEPTH + 1);
    localparam int IW = 5;
    localparam logic [12:0] LW1 = 13'(LINE_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        SELECT,
        UPDATE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic            vs_d1_q;
    logic            vs_rise;
    logic [3:0]      hist_q [HIST_DEPTH];
    logic [11:0]     hl_q, hr_q, vl_q, vr_q;

    logic [CW-1:0]   cnt_q [NUM_CLASS];
    logic [CW-1:0]   best_cnt_q;
    logic [3:0]      best_q;
    logic [3:0]      sort_q;
    logic            valid_q;
    logic            done_q;

    logic [3:0]      cur_code;
    logic [CW-1:0]   sel_cnt;

    logic [11:0]     hcnt_q, vcnt_q;
    logic [23:0]     rgb_q;
    logic            hs_q, vs_q, de_q;

    assign vs_rise = i_vsync & ~vs_d1_q;

    // Frame edge: shift history, latch box for the next frame.
    always_ff @(posedge pixelclk) begin
        if (rstin) begin
            vs_d1_q <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= 4'hF;
            hl_q <= '0;
            hr_q <= '0;
            vl_q <= '0;
            vr_q <= '0;
        end else begin
            vs_d1_q <= i_vsync;
            if (vs_rise) begin
                for (int i = HIST_DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
                hist_q[0] <= i_sort;
                hl_q <= hcount_l;
                hr_q <= hcount_r;
                vl_q <= vcount_l;
                vr_q <= vcount_r;
            end
        end
    end

    // Vote FSM state register.
    always_ff @(posedge pixelclk) begin
        if (rstin) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Vote FSM next state; a new frame edge always restarts the vote.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
            end
            CLEAR: begin
                state_d = COUNT;
                idx_d   = '0;
            end
            COUNT: begin
                if (idx_q == IW'(HIST_DEPTH - 1)) begin
                    state_d = SELECT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SELECT: begin
                if (idx_q == IW'(NUM_CLASS - 1)) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            UPDATE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (vs_rise) begin
            state_d = CLEAR;
            idx_d   = '0;
        end
    end

    // Select the history entry and class counter addressed by idx_q.
    always_comb begin
        cur_code = 4'hF;
        sel_cnt  = '0;
        for (int i = 0; i < HIST_DEPTH; i++)
            if (idx_q == IW'(i)) cur_code = hist_q[i];
        for (int c = 0; c < NUM_CLASS; c++)
            if (idx_q == IW'(c)) sel_cnt = cnt_q[c];
    end

    // Vote datapath: histogram, lowest-index argmax, result update.
    always_ff @(posedge pixelclk) begin
        if (rstin) begin
            for (int c = 0; c < NUM_CLASS; c++) cnt_q[c] <= '0;
            best_cnt_q <= '0;
            best_q     <= 4'hF;
            sort_q     <= 4'hF;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!vs_rise) begin
                unique case (state_q)
                    CLEAR: begin
                        for (int c = 0; c < NUM_CLASS; c++) cnt_q[c] <= '0;
                        best_cnt_q <= '0;
                        best_q     <= 4'hF;
                    end
                    COUNT: begin
                        for (int c = 0; c < NUM_CLASS; c++)
                            if (cur_code == 4'(c)) cnt_q[c] <= cnt_q[c] + 1'b1;
                    end
                    SELECT: begin
                        if (sel_cnt > best_cnt_q) begin
                            best_cnt_q <= sel_cnt;
                            best_q     <= idx_q[3:0];
                        end
                    end
                    UPDATE: begin
                        done_q <= 1'b1;
                        if (best_cnt_q >= CW'(MIN_VOTES)) begin
                            sort_q  <= best_q;
                            valid_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Pixel position counters, saturating at 4095.
    always_ff @(posedge pixelclk) begin
        if (rstin) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            if (i_de) begin
                if (hcnt_q != 12'hFFF) hcnt_q <= hcnt_q + 1'b1;
            end else begin
                hcnt_q <= '0;
            end
            if (vs_rise) begin
                vcnt_q <= '0;
            end else if (de_q && !i_de && vcnt_q != 12'hFFF) begin
                vcnt_q <= vcnt_q + 1'b1;
            end
        end
    end

    logic [12:0] hx, vy, hl, hr, vl, vr;
    logic [12:0] hl_end, hr_beg, vl_end, vr_beg;
    logic        box_ok, in_h, in_v, on_l, on_r, on_t, on_b, border;

    // Border test in 13 bits so the inner edges never wrap.
    always_comb begin
        hx     = {1'b0, hcnt_q};
        vy     = {1'b0, vcnt_q};
        hl     = {1'b0, hl_q};
        hr     = {1'b0, hr_q};
        vl     = {1'b0, vl_q};
        vr     = {1'b0, vr_q};
        hl_end = hl + LW1;
        vl_end = vl + LW1;
        hr_beg = (hr >= LW1) ? hr - LW1 : '0;
        vr_beg = (vr >= LW1) ? vr - LW1 : '0;
        box_ok = (hl < hr) && (vl < vr) && valid_q;
        in_h   = (hx >= hl) && (hx <= hr);
        in_v   = (vy >= vl) && (vy <= vr);
        on_l   = (hx >= hl) && (hx <= hl_end);
        on_r   = (hx >= hr_beg) && (hx <= hr);
        on_t   = (vy >= vl) && (vy <= vl_end);
        on_b   = (vy >= vr_beg) && (vy <= vr);
        border = box_ok && ((in_v && (on_l || on_r)) || (in_h && (on_t || on_b)));
    end

    // One-cycle video stage with the outline painted in.
    always_ff @(posedge pixelclk) begin
        if (rstin) begin
            rgb_q <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
        end else begin
            rgb_q <= (border && i_de) ? BOX_COLOR : i_rgb;
            hs_q  <= i_hsync;
            vs_q  <= i_vsync;
            de_q  <= i_de;
        end
    end

    assign o_rgb        = rgb_q;
    assign o_hsync      = hs_q;
    assign o_vsync      = vs_q;
    assign o_de         = de_q;
    assign o_sort       = sort_q;
    assign o_sort_valid = valid_q;
    assign o_frame_done = done_q;

endmodule
